// File: rtl/imem_port_arbiter.sv
// Arbitrates the single-port instruction memory between the fetch stage and the
// loader/debug port, with a starvation guard for the loader and an exclusive lock mode.
module imem_port_arbiter #(
  parameter int ADDR_W     = 8,
  parameter int DATA_W     = 32,
  parameter int DEPTH      = 256,
  parameter int STARVE_MAX = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              if_req,
  input  logic [ADDR_W-1:0] if_addr,
  output logic              if_gnt,
  output logic              if_rvalid,
  output logic [DATA_W-1:0] if_rdata,
  input  logic              ld_req,
  input  logic              ld_we,
  input  logic              ld_lock,
  input  logic [ADDR_W-1:0] ld_addr,
  input  logic [DATA_W-1:0] ld_wdata,
  output logic              ld_gnt,
  output logic              ld_rvalid,
  output logic [DATA_W-1:0] ld_rdata,
  output logic              ld_err,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_we,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam int CNT_W = $clog2(STARVE_MAX + 1);

  typedef enum logic {RUN, LOCK} state_t;

  state_t           state, state_next;
  logic [CNT_W-1:0] starve_cnt;
  logic             starved;
  logic             if_in_range;
  logic             ld_in_range;

  assign starved     = (starve_cnt == CNT_W'(STARVE_MAX));
  assign if_in_range = (32'(if_addr) < 32'(DEPTH));
  assign ld_in_range = (32'(ld_addr) < 32'(DEPTH));

  // The cycle in which ld_lock first rises is still arbitrated with RUN rules.
  always_comb begin
    state_next = state;
    if_gnt     = 1'b0;
    ld_gnt     = 1'b0;
    case (state)
      RUN: begin
        if (ld_lock) state_next = LOCK;
        ld_gnt = ld_req & (~if_req | starved);
        if_gnt = if_req & ~ld_gnt;
      end
      LOCK: begin
        if (!ld_lock) state_next = RUN;
        ld_gnt = ld_req;
      end
      default: state_next = RUN;
    endcase
    if (!rst_n) begin
      if_gnt = 1'b0;
      ld_gnt = 1'b0;
    end
  end

  assign mem_addr  = ld_gnt ? ld_addr : (if_gnt ? if_addr : '0);
  assign mem_we    = ld_gnt & ld_we & ld_in_range;
  assign mem_wdata = ld_wdata;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state      <= RUN;
      starve_cnt <= '0;
    end else begin
      state <= state_next;
      if (state == RUN && !ld_lock && ld_req && !ld_gnt) begin
        if (!starved) starve_cnt <= starve_cnt + CNT_W'(1);
      end else begin
        starve_cnt <= '0;
      end
    end
  end

  // Read data is captured at grant time; out-of-range reads return zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      if_rvalid <= 1'b0;
      if_rdata  <= '0;
      ld_rvalid <= 1'b0;
      ld_rdata  <= '0;
      ld_err    <= 1'b0;
    end else begin
      if_rvalid <= if_gnt;
      if (if_gnt) if_rdata <= if_in_range ? mem_rdata : '0;
      ld_rvalid <= ld_gnt & ~ld_we;
      if (ld_gnt && !ld_we) ld_rdata <= ld_in_range ? mem_rdata : '0;
      ld_err    <= ld_gnt & ~ld_in_range;
    end
  end

endmodule

// File: tb/tb_imem_port_arbiter.sv
// Randomized and directed bench for imem_port_arbiter against a cycle-level
// reference model of the arbitration rules and a reference copy of memory.
module tb_imem_port_arbiter;

  localparam int ADDR_W     = 8;
  localparam int DATA_W     = 32;
  localparam int DEPTH      = 16;
  localparam int STARVE_MAX = 4;

  logic              clk;
  logic              rst_n;
  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;
  logic              ld_req;
  logic              ld_we;
  logic              ld_lock;
  logic [ADDR_W-1:0] ld_addr;
  logic [DATA_W-1:0] ld_wdata;
  logic              ld_gnt;
  logic              ld_rvalid;
  logic [DATA_W-1:0] ld_rdata;
  logic              ld_err;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_we;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;

  imem_port_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .DEPTH(DEPTH), .STARVE_MAX(STARVE_MAX)
  ) dut (
    .clk(clk), .rst_n(rst_n),
    .if_req(if_req), .if_addr(if_addr), .if_gnt(if_gnt),
    .if_rvalid(if_rvalid), .if_rdata(if_rdata),
    .ld_req(ld_req), .ld_we(ld_we), .ld_lock(ld_lock), .ld_addr(ld_addr),
    .ld_wdata(ld_wdata), .ld_gnt(ld_gnt), .ld_rvalid(ld_rvalid),
    .ld_rdata(ld_rdata), .ld_err(ld_err),
    .mem_addr(mem_addr), .mem_we(mem_we), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // The physical memory spans the whole address space so out-of-range reads see junk.
  logic [DATA_W-1:0] env_mem [256];
  assign mem_rdata = env_mem[mem_addr];

  logic [DATA_W-1:0] ref_mem [DEPTH];
  bit                m_locked;
  int                m_denied;
  logic              exp_if_rvalid, exp_ld_rvalid, exp_ld_err;
  logic [DATA_W-1:0] exp_if_rdata, exp_ld_rdata;

  int tests_run;
  int tests_failed;

  task automatic check_output(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests_run++;
    if (got !== exp) begin
      tests_failed++;
      $display("[TB] FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic apply_stimulus(
    input logic rn, input logic ireq, input logic [ADDR_W-1:0] iaddr,
    input logic lreq, input logic lwe, input logic llock,
    input logic [ADDR_W-1:0] laddr, input logic [DATA_W-1:0] lwd);
    logic              e_if_gnt, e_ld_gnt, e_we, ld_ok, if_ok;
    logic [ADDR_W-1:0] e_addr;
    logic              d_we;
    logic [ADDR_W-1:0] d_addr;
    logic [DATA_W-1:0] d_wdata;
    rst_n = rn; if_req = ireq; if_addr = iaddr;
    ld_req = lreq; ld_we = lwe; ld_lock = llock; ld_addr = laddr; ld_wdata = lwd;
    #1;
    ld_ok = (int'(laddr) < DEPTH);
    if_ok = (int'(iaddr) < DEPTH);
    e_if_gnt = 1'b0;
    e_ld_gnt = 1'b0;
    if (rn) begin
      if (m_locked) e_ld_gnt = lreq;
      else begin
        e_ld_gnt = lreq && (!ireq || m_denied >= STARVE_MAX);
        e_if_gnt = ireq && !e_ld_gnt;
      end
    end
    e_we   = e_ld_gnt && lwe && ld_ok;
    e_addr = e_ld_gnt ? laddr : (e_if_gnt ? iaddr : '0);
    check_output("if_gnt", 32'(if_gnt), 32'(e_if_gnt));
    check_output("ld_gnt", 32'(ld_gnt), 32'(e_ld_gnt));
    check_output("mem_we", 32'(mem_we), 32'(e_we));
    check_output("mem_addr", 32'(mem_addr), 32'(e_addr));
    d_we = mem_we; d_addr = mem_addr; d_wdata = mem_wdata;
    @(posedge clk);
    if (d_we) env_mem[d_addr] = d_wdata;
    if (!rn) begin
      m_locked = 1'b0; m_denied = 0;
      exp_if_rvalid = 1'b0; exp_ld_rvalid = 1'b0; exp_ld_err = 1'b0;
      exp_if_rdata = '0; exp_ld_rdata = '0;
    end else begin
      exp_if_rvalid = e_if_gnt;
      if (e_if_gnt) begin
        if (if_ok) exp_if_rdata = ref_mem[iaddr];
        else exp_if_rdata = '0;
      end
      exp_ld_rvalid = e_ld_gnt && !lwe;
      if (e_ld_gnt && !lwe) begin
        if (ld_ok) exp_ld_rdata = ref_mem[laddr];
        else exp_ld_rdata = '0;
      end
      exp_ld_err = e_ld_gnt && !ld_ok;
      if (e_we) ref_mem[laddr] = lwd;
      if (!m_locked && !llock && lreq && !e_ld_gnt)
        m_denied = (m_denied + 1 > STARVE_MAX) ? STARVE_MAX : m_denied + 1;
      else
        m_denied = 0;
      m_locked = llock;
    end
    #1;
    check_output("if_rvalid", 32'(if_rvalid), 32'(exp_if_rvalid));
    check_output("if_rdata", if_rdata, exp_if_rdata);
    check_output("ld_rvalid", 32'(ld_rvalid), 32'(exp_ld_rvalid));
    check_output("ld_rdata", ld_rdata, exp_ld_rdata);
    check_output("ld_err", 32'(ld_err), 32'(exp_ld_err));
    @(negedge clk);
  endtask

  initial begin
    logic rl;
    tests_run = 0; tests_failed = 0;
    m_locked = 1'b0; m_denied = 0;
    for (int i = 0; i < 256; i++) env_mem[i] = $urandom;
    for (int i = 0; i < DEPTH; i++) ref_mem[i] = env_mem[i];
    rst_n = 1'b0; if_req = 1'b0; if_addr = '0; ld_req = 1'b0; ld_we = 1'b0;
    ld_lock = 1'b0; ld_addr = '0; ld_wdata = '0;
    @(negedge clk);
    apply_stimulus(0, 0, 0, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 1, 1, 0, 0, 1, 0);

    // Fetch stream, then a loader read starved until the guard fires.
    for (int a = 0; a < 14; a++) apply_stimulus(1, 1, ADDR_W'(a), 0, 0, 0, 0, 0);
    for (int c = 0; c < 12; c++) apply_stimulus(1, 1, ADDR_W'(c), 1, 0, 0, 5, 0);

    // Fetch granted as lock rises, then a locked download and unlock.
    apply_stimulus(1, 1, 2, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 3, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 4, 1, 1, 1, 0, 32'hDEADBEEF);
    apply_stimulus(1, 1, 4, 1, 1, 1, 1, 32'h12345678);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 0, 0, 0, 0, 0, 0);
    check_output("dl_word0", if_rdata, 32'hDEADBEEF);
    apply_stimulus(1, 1, 1, 0, 0, 0, 0, 0);
    check_output("dl_word1", if_rdata, 32'h12345678);

    // Out-of-range accesses from both requesters.
    apply_stimulus(1, 0, 0, 1, 1, 0, 20, 32'hCAFEF00D);
    apply_stimulus(1, 0, 0, 1, 0, 0, 20, 0);
    apply_stimulus(1, 1, 20, 0, 0, 0, 0, 0);
    apply_stimulus(1, 1, 255, 1, 0, 0, 255, 0);

    // Reset during a read, and reset while lock is held.
    apply_stimulus(1, 1, 3, 0, 0, 0, 0, 0);
    apply_stimulus(0, 1, 3, 1, 0, 0, 3, 0);
    apply_stimulus(1, 0, 0, 0, 0, 1, 0, 0);
    apply_stimulus(1, 1, 5, 1, 0, 1, 6, 0);
    apply_stimulus(0, 1, 5, 1, 0, 1, 6, 0);
    apply_stimulus(1, 1, 5, 1, 0, 1, 6, 0);
    apply_stimulus(1, 1, 5, 1, 0, 1, 6, 0);
    apply_stimulus(1, 1, 5, 0, 0, 0, 6, 0);

    rl = 1'b0;
    for (int n = 0; n < 600; n++) begin
      if ($urandom_range(0, 19) == 0) rl = ~rl;
      apply_stimulus(
        ($urandom_range(0, 63) != 0),
        ($urandom_range(0, 3) != 0),
        ADDR_W'($urandom_range(0, 23)),
        ($urandom_range(0, 1) != 0),
        ($urandom_range(0, 2) == 0),
        rl,
        ADDR_W'($urandom_range(0, 23)),
        DATA_W'($urandom));
    end

    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
